// File: rtl/dmem_access_unit.sv
`timescale 1ns/1ps
// Memory-stage load/store engine: req/gnt/rvalid handshake, byte-lane steering, load extension.
// Accept->RESP is 3 cycles (store) / 4 (load) at best; upstream is stalled through REQ and WAIT.
module dmem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ex_valid,
  input  logic [6:0]  ex_opcode,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wbe,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic        misaligned_exc,
  output logic        bus_err,
  output logic [31:0] exc_addr
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam bit         TO_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [7:0] TO_LIMIT = TO_EN ? 8'(TIMEOUT_CYCLES - 1) : 8'd0;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t      state;
  logic [7:0]  cnt;
  logic [31:0] lat_addr;
  logic [2:0]  lat_f3;
  logic        lat_load;

  logic        is_load, is_store, legal, aligned, accept, timeout_hit;
  logic [1:0]  off;
  logic [3:0]  wbe_c;
  logic [31:0] wdata_c, sh, ext;

  always_comb begin
    off      = ex_addr[1:0];
    is_load  = (ex_opcode == OP_LOAD);
    is_store = (ex_opcode == OP_STORE);
    legal    = 1'b0;
    if (is_load)
      legal = ex_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    else if (is_store)
      legal = ex_funct3 inside {3'b000, 3'b001, 3'b010};
    case (ex_funct3[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = (off != 2'b11);
      default: aligned = (off == 2'b00);
    endcase
    wbe_c   = 4'b0000;
    wdata_c = 32'd0;
    if (is_store) begin
      case (ex_funct3[1:0])
        2'b00:   wbe_c = 4'b0001 << off;
        2'b01:   wbe_c = 4'b0011 << off;
        default: wbe_c = 4'b1111;
      endcase
      wdata_c = ex_wdata << {off, 3'b000};
    end
  end

  assign accept         = (state == S_IDLE) && ex_valid && legal && aligned;
  assign misaligned_exc = (state == S_IDLE) && ex_valid && legal && !aligned;
  assign mem_req        = (state == S_REQ);
  assign stall          = accept || (state == S_REQ) || (state == S_WAIT);
  assign timeout_hit    = TO_EN && (cnt == TO_LIMIT);

  // Extraction uses the latched offset/size, never the live EX inputs.
  always_comb begin
    sh = mem_rdata >> {lat_addr[1:0], 3'b000};
    case (lat_f3)
      3'b000:  ext = {{24{sh[7]}}, sh[7:0]};
      3'b001:  ext = {{16{sh[15]}}, sh[15:0]};
      3'b100:  ext = {24'd0, sh[7:0]};
      3'b101:  ext = {16'd0, sh[15:0]};
      default: ext = sh;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cnt       <= 8'd0;
      lat_addr  <= 32'd0;
      lat_f3    <= 3'd0;
      lat_load  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wbe   <= 4'd0;
      mem_wdata <= 32'd0;
      wb_valid  <= 1'b0;
      wb_data   <= 32'd0;
      bus_err   <= 1'b0;
      exc_addr  <= 32'd0;
    end else begin
      wb_valid <= 1'b0;
      bus_err  <= 1'b0;
      if (misaligned_exc)
        exc_addr <= ex_addr;
      case (state)
        S_IDLE: begin
          if (accept) begin
            lat_addr  <= ex_addr;
            lat_f3    <= ex_funct3;
            lat_load  <= is_load;
            mem_we    <= is_store;
            mem_addr  <= {ex_addr[31:2], 2'b00};
            mem_wbe   <= wbe_c;
            mem_wdata <= wdata_c;
            cnt       <= 8'd0;
            state     <= S_REQ;
          end
        end
        S_REQ: begin
          // A grant landing on the limit cycle still completes the access.
          if (mem_gnt) begin
            cnt   <= 8'd0;
            state <= lat_load ? S_WAIT : S_RESP;
          end else if (timeout_hit) begin
            bus_err  <= 1'b1;
            exc_addr <= lat_addr;
            state    <= S_RESP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            wb_data  <= ext;
            wb_valid <= 1'b1;
            state    <= S_RESP;
          end else if (timeout_hit) begin
            bus_err  <= 1'b1;
            exc_addr <= lat_addr;
            state    <= S_RESP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
`timescale 1ns/1ps
// Scoreboard bench for dmem_access_unit with a scripted gnt/rvalid memory responder.
module tb_dmem_access_unit;

  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;

  // {funct3, addr, expected wb_data}; mem_rdata is 0x80FF1234 for all rows
  localparam logic [66:0] LD_TAB [6] = '{
    {3'b000, 32'h0000_1003, 32'hFFFF_FF80},
    {3'b100, 32'h0000_1003, 32'h0000_0080},
    {3'b001, 32'h0000_1002, 32'hFFFF_80FF},
    {3'b101, 32'h0000_1001, 32'h0000_FF12},
    {3'b010, 32'h0000_1000, 32'h80FF_1234},
    {3'b000, 32'h0000_1001, 32'h0000_0012}
  };
  // {funct3, addr, wdata, exp mem_addr, exp wbe, exp mem_wdata}
  localparam logic [134:0] ST_TAB [4] = '{
    {3'b001, 32'h0000_2001, 32'h0000_BEEF, 32'h0000_2000, 4'b0110, 32'h00BE_EF00},
    {3'b000, 32'h0000_3003, 32'h0000_00AB, 32'h0000_3000, 4'b1000, 32'hAB00_0000},
    {3'b010, 32'h0000_3000, 32'h1234_5678, 32'h0000_3000, 4'b1111, 32'h1234_5678},
    {3'b000, 32'h0000_3001, 32'h0000_00CD, 32'h0000_3000, 4'b0010, 32'h0000_CD00}
  };

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ex_valid;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr, ex_wdata;
  logic        stall, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wbe;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        wb_valid, misaligned_exc, bus_err;
  logic [31:0] wb_data, exc_addr;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb_wb [$];
  logic [67:0] sb_wr [$];

  typedef struct {
    logic        accepted;
    logic        misal0;
    int          lat;
    int          reqc;
    logic        stable;
    logic        we;
    logic [31:0] waddr;
    logic [3:0]  wbe;
    logic [31:0] wdat;
    logic        wb_seen;
    logic [31:0] wb_d;
    logic        berr;
    logic [31:0] exc;
    logic        pulse_ok;
  } acc_t;

  dmem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_funct3(ex_funct3),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wbe(mem_wbe), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_data(wb_data),
    .misaligned_exc(misaligned_exc), .bus_err(bus_err), .exc_addr(exc_addr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one EX instruction; gnt/rvalid pulse on the given cycle index after accept (0 = never).
  task automatic do_access(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input int gnt_cyc, input int rv_cyc, output acc_t r);
    logic first;
    r.accepted = 0; r.misal0 = 0; r.lat = -1; r.reqc = 0; r.stable = 1; r.we = 0;
    r.waddr = 0; r.wbe = 0; r.wdat = 0; r.wb_seen = 0; r.wb_d = 0; r.berr = 0; r.exc = 0;
    r.pulse_ok = 0;
    first = 1;
    step();
    ex_valid = 1; ex_opcode = op; ex_funct3 = f3; ex_addr = addr; ex_wdata = wdata;
    mem_rdata = rdata; mem_gnt = 0; mem_rvalid = 0;
    @(negedge clk);
    r.accepted = stall;
    r.misal0   = misaligned_exc;
    if (mem_req) r.reqc++;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      step();
      ex_valid = 0; ex_opcode = LD; ex_funct3 = 3'b111;
      ex_addr = 32'hFFFF_FFFF; ex_wdata = 32'h5A5A_5A5A;
      mem_gnt = (cyc == gnt_cyc);
      mem_rvalid = (cyc == rv_cyc);
      @(negedge clk);
      if (mem_req) begin
        r.reqc++;
        if (first) begin
          r.we = mem_we; r.waddr = mem_addr; r.wbe = mem_wbe; r.wdat = mem_wdata;
          first = 0;
        end else if ({mem_we, mem_addr, mem_wbe, mem_wdata} !== {r.we, r.waddr, r.wbe, r.wdat}) begin
          r.stable = 0;
        end
      end
      if (!r.accepted) begin
        if (cyc == 1) r.exc = exc_addr;
        if (cyc == 3) break;
      end else if (!stall) begin
        r.lat = cyc; r.wb_seen = wb_valid; r.wb_d = wb_data; r.berr = bus_err; r.exc = exc_addr;
        break;
      end
    end
    step();
    mem_gnt = 0; mem_rvalid = 0;
    @(negedge clk);
    r.pulse_ok = !wb_valid && !bus_err && !stall;
  endtask

  task automatic test_reset();
    reset_n = 0; ex_valid = 0; ex_opcode = 0; ex_funct3 = 0; ex_addr = 0; ex_wdata = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    #12;
    checks++;
    if ({stall, mem_req, mem_we, wb_valid, misaligned_exc, bus_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got stall/req/we/wbv/mis/berr=%b want 000000",
               {stall, mem_req, mem_we, wb_valid, misaligned_exc, bus_err});
    end
    checks++;
    if ({mem_addr, mem_wdata, wb_data, exc_addr, mem_wbe} !== 132'd0) begin
      errors++;
      $display("FAIL reset_data: got addr=%h wdata=%h wb=%h exc=%h wbe=%b want all 0",
               mem_addr, mem_wdata, wb_data, exc_addr, mem_wbe);
    end
    step();
    reset_n = 1;
  endtask

  task automatic test_loads();
    acc_t r;
    logic [66:0] e;
    logic [31:0] exp_d;
    for (int i = 0; i < 6; i++) begin
      e = LD_TAB[i];
      sb_wb.push_back(e[31:0]);
      do_access(LD, e[66:64], e[63:32], 32'h0, 32'h80FF_1234, 1, 2, r);
      exp_d = sb_wb.pop_front();
      checks++;
      if (r.wb_seen !== 1'b1 || r.wb_d !== exp_d) begin
        errors++;
        $display("FAIL load%0d_data: got vld=%b data=%h want vld=1 data=%h", i, r.wb_seen, r.wb_d, exp_d);
      end
      checks++;
      if (r.lat != 3 || r.reqc != 1 || r.we !== 1'b0 || r.wbe !== 4'b0) begin
        errors++;
        $display("FAIL load%0d_timing: got lat=%0d req=%0d we=%b wbe=%b want lat=3 req=1 we=0 wbe=0000",
                 i, r.lat, r.reqc, r.we, r.wbe);
      end
      checks++;
      if (r.pulse_ok !== 1'b1) begin
        errors++;
        $display("FAIL load%0d_pulse: got wb_valid/stall still high after RESP want low", i);
      end
    end
  endtask

  task automatic test_stores();
    acc_t r;
    logic [134:0] e;
    logic [67:0]  exp_w;
    for (int i = 0; i < 4; i++) begin
      e = ST_TAB[i];
      sb_wr.push_back(e[67:0]);
      do_access(ST, e[134:132], e[131:100], e[99:68], 32'h0, 1, 0, r);
      exp_w = sb_wr.pop_front();
      checks++;
      if (r.we !== 1'b1 || {r.waddr, r.wbe, r.wdat} !== exp_w) begin
        errors++;
        $display("FAIL store%0d_bus: got we=%b addr=%h wbe=%b wdata=%h want we=1 addr=%h wbe=%b wdata=%h",
                 i, r.we, r.waddr, r.wbe, r.wdat, exp_w[67:36], exp_w[35:32], exp_w[31:0]);
      end
      checks++;
      if (r.accepted !== 1'b1 || r.lat != 2 || r.reqc != 1) begin
        errors++;
        $display("FAIL store%0d_timing: got acc=%b lat=%0d req=%0d want acc=1 lat=2 req=1",
                 i, r.accepted, r.lat, r.reqc);
      end
      checks++;
      if (r.wb_seen !== 1'b0 || r.pulse_ok !== 1'b1) begin
        errors++;
        $display("FAIL store%0d_resp: got wb_valid=%b released=%b want 0 1", i, r.wb_seen, r.pulse_ok);
      end
    end
  endtask

  task automatic test_slow_load();
    acc_t r;
    logic [31:0] exp_d;
    sb_wb.push_back(32'hCAFE_F00D);
    do_access(LD, 3'b010, 32'h0000_1000, 32'h0, 32'hCAFE_F00D, 4, 6, r);
    exp_d = sb_wb.pop_front();
    checks++;
    if (r.wb_seen !== 1'b1 || r.wb_d !== exp_d) begin
      errors++;
      $display("FAIL slow_data: got vld=%b data=%h want vld=1 data=%h", r.wb_seen, r.wb_d, exp_d);
    end
    checks++;
    if (r.reqc != 4 || r.stable !== 1'b1 || r.waddr !== 32'h0000_1000) begin
      errors++;
      $display("FAIL slow_req: got req=%0d stable=%b addr=%h want req=4 stable=1 addr=00001000",
               r.reqc, r.stable, r.waddr);
    end
    checks++;
    if (r.lat != 7) begin
      errors++;
      $display("FAIL slow_latency: got lat=%0d want 7", r.lat);
    end
  endtask

  task automatic test_misaligned();
    acc_t r;
    logic [2:0]  f3s [4];
    logic [6:0]  ops [4];
    logic [31:0] adrs [4];
    logic [31:0] exps [4];
    logic        mis [4];
    f3s[0] = 3'b010; ops[0] = LD; adrs[0] = 32'h1002; exps[0] = 32'h1002; mis[0] = 1;
    f3s[1] = 3'b001; ops[1] = LD; adrs[1] = 32'h1003; exps[1] = 32'h1003; mis[1] = 1;
    f3s[2] = 3'b010; ops[2] = ST; adrs[2] = 32'h2002; exps[2] = 32'h2002; mis[2] = 1;
    f3s[3] = 3'b011; ops[3] = LD; adrs[3] = 32'h1001; exps[3] = 32'h2002; mis[3] = 0;
    for (int i = 0; i < 4; i++) begin
      do_access(ops[i], f3s[i], adrs[i], 32'h1111_2222, 32'h0, 1, 2, r);
      checks++;
      if (r.accepted !== 1'b0 || r.misal0 !== mis[i] || r.reqc != 0) begin
        errors++;
        $display("FAIL misal%0d_ctrl: got stall=%b exc=%b req=%0d want stall=0 exc=%b req=0",
                 i, r.accepted, r.misal0, r.reqc, mis[i]);
      end
      checks++;
      if (r.exc !== exps[i]) begin
        errors++;
        $display("FAIL misal%0d_addr: got exc_addr=%h want %h", i, r.exc, exps[i]);
      end
    end
  endtask

  task automatic test_timeout();
    acc_t r;
    logic [67:0] exp_w;
    do_access(LD, 3'b010, 32'h0000_4000, 32'h0, 32'h0, 0, 0, r);
    checks++;
    if (r.berr !== 1'b1 || r.wb_seen !== 1'b0 || r.reqc != 4 || r.lat != 5) begin
      errors++;
      $display("FAIL timeout_req: got berr=%b wbv=%b req=%0d lat=%0d want 1 0 4 5",
               r.berr, r.wb_seen, r.reqc, r.lat);
    end
    checks++;
    if (r.exc !== 32'h0000_4000 || r.pulse_ok !== 1'b1) begin
      errors++;
      $display("FAIL timeout_exc: got exc=%h released=%b want 00004000 1", r.exc, r.pulse_ok);
    end
    do_access(LD, 3'b010, 32'h0000_4008, 32'h0, 32'h0, 1, 0, r);
    checks++;
    if (r.berr !== 1'b1 || r.wb_seen !== 1'b0 || r.lat != 6 || r.exc !== 32'h0000_4008) begin
      errors++;
      $display("FAIL timeout_wait: got berr=%b wbv=%b lat=%0d exc=%h want 1 0 6 00004008",
               r.berr, r.wb_seen, r.lat, r.exc);
    end
    sb_wr.push_back({32'h0000_4004, 4'b1111, 32'hA5A5_A5A5});
    do_access(ST, 3'b010, 32'h0000_4004, 32'hA5A5_A5A5, 32'h0, 1, 0, r);
    exp_w = sb_wr.pop_front();
    checks++;
    if (r.we !== 1'b1 || {r.waddr, r.wbe, r.wdat} !== exp_w || r.lat != 2 || r.berr !== 1'b0) begin
      errors++;
      $display("FAIL b2b_store: got addr=%h wbe=%b wdata=%h lat=%0d berr=%b want %h %b %h 2 0",
               r.waddr, r.wbe, r.wdat, r.lat, r.berr, exp_w[67:36], exp_w[35:32], exp_w[31:0]);
    end
  endtask

  task automatic test_reset_midflight();
    logic seen;
    for (int v = 0; v < 2; v++) begin
      step();
      ex_valid = 1; ex_opcode = LD; ex_funct3 = 3'b010; ex_addr = 32'h5000; mem_rdata = 32'h7777_7777;
      mem_gnt = 0; mem_rvalid = 0;
      step();
      ex_valid = 0;
      mem_gnt = (v == 1);
      if (v == 1) begin
        step();
        mem_gnt = 0;
      end
      @(negedge clk);
      checks++;
      if (stall !== 1'b1 || mem_req !== (v == 0)) begin
        errors++;
        $display("FAIL rst%0d_before: got stall=%b req=%b want stall=1 req=%b", v, stall, mem_req, v == 0);
      end
      #2;
      reset_n = 0;
      #1;
      checks++;
      if (stall !== 1'b0 || mem_req !== 1'b0 || exc_addr !== 32'd0) begin
        errors++;
        $display("FAIL rst%0d_async: got stall=%b req=%b exc=%h want 0 0 0", v, stall, mem_req, exc_addr);
      end
      step();
      reset_n = 1;
      seen = 0;
      for (int c = 0; c < 4; c++) begin
        step();
        mem_rvalid = 1; mem_gnt = 1;
        @(negedge clk);
        if (wb_valid || stall || mem_req) seen = 1;
      end
      mem_rvalid = 0; mem_gnt = 0;
      checks++;
      if (seen !== 1'b0) begin
        errors++;
        $display("FAIL rst%0d_late_rvalid: got wb_valid/stall/req activity=1 want 0", v);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion by 100us want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_slow_load();
    test_misaligned();
    test_timeout();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
